// File: rtl/cache_pkg.sv
// Shared line-state encodings and controller FSM states for the set-associative
// line storage.
package cache_pkg;

  localparam int ST_WIDTH = 2;

  typedef enum logic [ST_WIDTH-1:0] {
    ST_INVALID   = 2'd0,
    ST_SHARED    = 2'd1,
    ST_EXCLUSIVE = 2'd2,
    ST_MODIFIED  = 2'd3
  } st_e;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } fsm_e;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: victim walk from the node bits, plus the updated
// bits after touching a way. Node i has children 2i+1 (lower half) and 2i+2.
module plru_tree #(
  parameter int NUM_WAY = 4,
  localparam int WAY_WIDTH = $clog2(NUM_WAY)
) (
  input  logic [NUM_WAY-2:0]   plru,
  input  logic [WAY_WIDTH-1:0] touch_way,
  output logic [WAY_WIDTH-1:0] victim,
  output logic [NUM_WAY-2:0]   next_plru
);

  // Each node bit picks a half; the path from root to leaf spells the way MSB first.
  always_comb begin
    int node;
    victim = '0;
    node   = 0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      victim[WAY_WIDTH-1-l] = plru[node];
      node = 2 * node + 1 + int'(plru[node]);
    end
  end

  always_comb begin
    int   node;
    logic dir;
    next_plru = plru;
    node      = 0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      dir             = touch_way[WAY_WIDTH-1-l];
      next_plru[node] = ~dir;
      node            = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/cac_set_storage.sv
// Set-associative {state, tag, data} line storage with tree pseudo-LRU, serving a
// core-side and a snoop-side lookup/write channel; cleared by a post-reset sweep.
module cac_set_storage
  import cache_pkg::*;
#(
  parameter int NUM_SET     = 16,
  parameter int NUM_WAY     = 4,
  parameter int BLK_WIDTH   = 32,
  parameter int SADDR_WIDTH = 32,
  localparam int IDX_WIDTH  = $clog2(NUM_SET),
  localparam int WAY_WIDTH  = $clog2(NUM_WAY),
  localparam int TAG_WIDTH  = SADDR_WIDTH - IDX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   init_done,
  input  logic                   cd_lkup_vld,
  input  logic [SADDR_WIDTH-1:0] cd_lkup_addr,
  input  logic                   su_lkup_vld,
  input  logic [SADDR_WIDTH-1:0] su_lkup_addr,
  output logic                   cd_rsp_vld,
  output logic                   cd_hit,
  output logic [WAY_WIDTH-1:0]   cd_hit_way,
  output logic [ST_WIDTH-1:0]    cd_st,
  output logic [BLK_WIDTH-1:0]   cd_data,
  output logic [WAY_WIDTH-1:0]   cd_victim_way,
  output logic [ST_WIDTH-1:0]    cd_victim_st,
  output logic [TAG_WIDTH-1:0]   cd_victim_tag,
  output logic [BLK_WIDTH-1:0]   cd_victim_data,
  output logic                   su_rsp_vld,
  output logic                   su_hit,
  output logic [WAY_WIDTH-1:0]   su_hit_way,
  output logic [ST_WIDTH-1:0]    su_st,
  output logic [BLK_WIDTH-1:0]   su_data,
  input  logic                   cd_wr_en,
  input  logic [SADDR_WIDTH-1:0] cd_wr_addr,
  input  logic [WAY_WIDTH-1:0]   cd_wr_way,
  input  logic                   cd_wr_st_en,
  input  logic                   cd_wr_tag_en,
  input  logic                   cd_wr_dat_en,
  input  logic [ST_WIDTH-1:0]    cd_wr_st,
  input  logic [BLK_WIDTH-1:0]   cd_wr_data,
  input  logic                   su_wr_en,
  input  logic [SADDR_WIDTH-1:0] su_wr_addr,
  input  logic [WAY_WIDTH-1:0]   su_wr_way,
  input  logic                   su_wr_st_en,
  input  logic                   su_wr_dat_en,
  input  logic [ST_WIDTH-1:0]    su_wr_st,
  input  logic [BLK_WIDTH-1:0]   su_wr_data
);

  typedef struct packed {
    logic [ST_WIDTH-1:0]  st;
    logic [TAG_WIDTH-1:0] tag;
    logic [BLK_WIDTH-1:0] data;
  } line_t;

  typedef struct packed {
    logic                 vld;
    logic                 hit;
    logic [WAY_WIDTH-1:0] way;
    line_t                line;
  } rsp_t;

  line_t              mem  [NUM_SET][NUM_WAY];
  logic [NUM_WAY-2:0] plru [NUM_SET];

  fsm_e                 state, state_nxt;
  logic [IDX_WIDTH-1:0] cnt, cnt_nxt;
  logic                 sweep, ready, wr_ok;

  logic [IDX_WIDTH-1:0] cd_idx, su_idx, cd_wr_idx, su_wr_idx;
  logic [TAG_WIDTH-1:0] cd_tag, su_tag;
  logic                 cd_acc, su_acc, cd_fill;
  rsp_t                 cd_rsp_d, su_rsp_d, cd_rsp_q, su_rsp_q, vic_d, vic_q;
  logic [WAY_WIDTH-1:0] plru_vic, inv_way;
  logic                 inv_found;
  logic [NUM_WAY-2:0]   hit_plru, fill_plru;

  assign cd_idx    = cd_lkup_addr[IDX_WIDTH-1:0];
  assign su_idx    = su_lkup_addr[IDX_WIDTH-1:0];
  assign cd_tag    = cd_lkup_addr[SADDR_WIDTH-1:IDX_WIDTH];
  assign su_tag    = su_lkup_addr[SADDR_WIDTH-1:IDX_WIDTH];
  assign cd_wr_idx = cd_wr_addr[IDX_WIDTH-1:0];
  assign su_wr_idx = su_wr_addr[IDX_WIDTH-1:0];

  assign ready     = (state == S_READY);
  assign wr_ok     = ready && !rst;
  assign init_done = ready;
  assign cd_acc    = cd_lkup_vld && ready;
  assign su_acc    = su_lkup_vld && ready;
  assign cd_fill   = cd_wr_en && cd_wr_tag_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sweep     = 1'b0;
    case (state)
      S_INIT: begin
        sweep   = 1'b1;
        cnt_nxt = cnt + IDX_WIDTH'(1);
        if (cnt == IDX_WIDTH'(NUM_SET - 1)) state_nxt = S_READY;
      end
      default: ;
    endcase
  end

  // Descending scan so the lowest matching way wins on a multi-hit.
  always_comb begin
    cd_rsp_d     = '0;
    su_rsp_d     = '0;
    cd_rsp_d.vld = cd_acc;
    su_rsp_d.vld = su_acc;
    for (int w = NUM_WAY - 1; w >= 0; w--) begin
      if (mem[cd_idx][w].st != ST_INVALID && mem[cd_idx][w].tag == cd_tag) begin
        cd_rsp_d.hit       = 1'b1;
        cd_rsp_d.way       = WAY_WIDTH'(w);
        cd_rsp_d.line.st   = mem[cd_idx][w].st;
        cd_rsp_d.line.data = mem[cd_idx][w].data;
      end
      if (mem[su_idx][w].st != ST_INVALID && mem[su_idx][w].tag == su_tag) begin
        su_rsp_d.hit       = 1'b1;
        su_rsp_d.way       = WAY_WIDTH'(w);
        su_rsp_d.line.st   = mem[su_idx][w].st;
        su_rsp_d.line.data = mem[su_idx][w].data;
      end
    end
  end

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NUM_WAY - 1; w >= 0; w--) begin
      if (mem[cd_idx][w].st == ST_INVALID) begin
        inv_found = 1'b1;
        inv_way   = WAY_WIDTH'(w);
      end
    end
    vic_d      = '0;
    vic_d.vld  = cd_acc;
    vic_d.way  = inv_found ? inv_way : plru_vic;
    vic_d.line = mem[cd_idx][vic_d.way];
  end

  plru_tree #(.NUM_WAY(NUM_WAY)) u_lkup_plru (
    .plru      (plru[cd_idx]),
    .touch_way (cd_rsp_d.way),
    .victim    (plru_vic),
    .next_plru (hit_plru)
  );

  plru_tree #(.NUM_WAY(NUM_WAY)) u_fill_plru (
    .plru      (plru[cd_wr_idx]),
    .touch_way (cd_wr_way),
    .victim    (),
    .next_plru (fill_plru)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cd_rsp_q <= '0;
      su_rsp_q <= '0;
      vic_q    <= '0;
    end else begin
      cd_rsp_q <= cd_acc ? cd_rsp_d : '0;
      su_rsp_q <= su_acc ? su_rsp_d : '0;
      vic_q    <= cd_acc ? vic_d : '0;
    end
  end

  // NOTE: the line array has no reset term; the init sweep clears it one set per
  // cycle, which keeps the storage a plain register file without a wide reset.
  // Later assignments win, so cd field writes override su and a fill's PLRU touch
  // overrides a same-set hit touch.
  always_ff @(posedge clk) begin
    if (sweep) begin
      for (int w = 0; w < NUM_WAY; w++) mem[cnt][w] <= '0;
      plru[cnt] <= '0;
    end else if (wr_ok) begin
      if (cd_acc && cd_rsp_d.hit) plru[cd_idx] <= hit_plru;
      if (cd_fill)                plru[cd_wr_idx] <= fill_plru;
      if (su_wr_en && su_wr_st_en)  mem[su_wr_idx][su_wr_way].st   <= su_wr_st;
      if (su_wr_en && su_wr_dat_en) mem[su_wr_idx][su_wr_way].data <= su_wr_data;
      if (cd_wr_en && cd_wr_st_en)  mem[cd_wr_idx][cd_wr_way].st   <= cd_wr_st;
      if (cd_wr_en && cd_wr_tag_en) mem[cd_wr_idx][cd_wr_way].tag  <= cd_wr_addr[SADDR_WIDTH-1:IDX_WIDTH];
      if (cd_wr_en && cd_wr_dat_en) mem[cd_wr_idx][cd_wr_way].data <= cd_wr_data;
    end
  end

  assign cd_rsp_vld     = cd_rsp_q.vld;
  assign cd_hit         = cd_rsp_q.hit;
  assign cd_hit_way     = cd_rsp_q.way;
  assign cd_st          = cd_rsp_q.line.st;
  assign cd_data        = cd_rsp_q.line.data;
  assign cd_victim_way  = vic_q.way;
  assign cd_victim_st   = vic_q.line.st;
  assign cd_victim_tag  = vic_q.line.tag;
  assign cd_victim_data = vic_q.line.data;
  assign su_rsp_vld     = su_rsp_q.vld;
  assign su_hit         = su_rsp_q.hit;
  assign su_hit_way     = su_rsp_q.way;
  assign su_st          = su_rsp_q.line.st;
  assign su_data        = su_rsp_q.line.data;

endmodule

// File: tb/tb_cac_set_storage.sv
// Bench for cac_set_storage: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a line-level reference model.
module tb_cac_set_storage;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        cd_lkup_vld, su_lkup_vld;
  logic [31:0] cd_lkup_addr, su_lkup_addr;
  logic        cd_rsp_vld, cd_hit, su_rsp_vld, su_hit;
  logic [1:0]  cd_hit_way, su_hit_way, cd_victim_way;
  logic [1:0]  cd_st, su_st, cd_victim_st;
  logic [31:0] cd_data, su_data, cd_victim_data;
  logic [27:0] cd_victim_tag;
  logic        cd_wr_en, cd_wr_st_en, cd_wr_tag_en, cd_wr_dat_en;
  logic [31:0] cd_wr_addr, cd_wr_data;
  logic [1:0]  cd_wr_way, cd_wr_st;
  logic        su_wr_en, su_wr_st_en, su_wr_dat_en;
  logic [31:0] su_wr_addr, su_wr_data;
  logic [1:0]  su_wr_way, su_wr_st;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cac_set_storage dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .cd_lkup_vld(cd_lkup_vld), .cd_lkup_addr(cd_lkup_addr),
    .su_lkup_vld(su_lkup_vld), .su_lkup_addr(su_lkup_addr),
    .cd_rsp_vld(cd_rsp_vld), .cd_hit(cd_hit), .cd_hit_way(cd_hit_way),
    .cd_st(cd_st), .cd_data(cd_data), .cd_victim_way(cd_victim_way),
    .cd_victim_st(cd_victim_st), .cd_victim_tag(cd_victim_tag),
    .cd_victim_data(cd_victim_data),
    .su_rsp_vld(su_rsp_vld), .su_hit(su_hit), .su_hit_way(su_hit_way),
    .su_st(su_st), .su_data(su_data),
    .cd_wr_en(cd_wr_en), .cd_wr_addr(cd_wr_addr), .cd_wr_way(cd_wr_way),
    .cd_wr_st_en(cd_wr_st_en), .cd_wr_tag_en(cd_wr_tag_en),
    .cd_wr_dat_en(cd_wr_dat_en), .cd_wr_st(cd_wr_st), .cd_wr_data(cd_wr_data),
    .su_wr_en(su_wr_en), .su_wr_addr(su_wr_addr), .su_wr_way(su_wr_way),
    .su_wr_st_en(su_wr_st_en), .su_wr_dat_en(su_wr_dat_en),
    .su_wr_st(su_wr_st), .su_wr_data(su_wr_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one entry per (set, way), PLRU as a heap of node bits.
  logic [1:0]  m_st   [16][4];
  logic [27:0] m_tag  [16][4];
  logic [31:0] m_data [16][4];
  logic [2:0]  m_plru [16];
  bit          m_ready = 1'b0;
  int          m_cnt = 0;

  bit          e_cd_vld = 1'b0, e_su_vld = 1'b0;
  int          e_cd_way, e_su_way, e_vic_way;
  logic [1:0]  e_cd_st, e_su_st, e_vic_st;
  logic [31:0] e_cd_data, e_su_data, e_vic_data;
  logic [27:0] e_vic_tag;
  int          cs, ss, fs;

  function automatic int find_hit(input int s, input logic [27:0] t);
    for (int w = 0; w < 4; w++)
      if (m_st[s][w] != 2'd0 && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  function automatic int pick_victim(input int s);
    int lo, span, node;
    for (int w = 0; w < 4; w++)
      if (m_st[s][w] == 2'd0) return w;
    lo = 0; span = 4; node = 0;
    while (span > 1) begin
      if (m_plru[s][node] == 1'b0) node = 2 * node + 1;
      else begin
        lo = lo + span / 2;
        node = 2 * node + 2;
      end
      span = span / 2;
    end
    return lo;
  endfunction

  function automatic void touch(input int s, input int way);
    int lo, span, node;
    lo = 0; span = 4; node = 0;
    while (span > 1) begin
      if (way < lo + span / 2) begin
        m_plru[s][node] = 1'b1;
        node = 2 * node + 1;
      end else begin
        m_plru[s][node] = 1'b0;
        lo = lo + span / 2;
        node = 2 * node + 2;
      end
      span = span / 2;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b0; m_cnt = 0; e_cd_vld = 1'b0; e_su_vld = 1'b0;
    end else if (!m_ready) begin
      for (int w = 0; w < 4; w++) begin
        m_st[m_cnt][w] = '0; m_tag[m_cnt][w] = '0; m_data[m_cnt][w] = '0;
      end
      m_plru[m_cnt] = '0;
      if (m_cnt == 15) m_ready = 1'b1;
      m_cnt = (m_cnt + 1) % 16;
      e_cd_vld = 1'b0; e_su_vld = 1'b0;
    end else begin
      cs = int'(cd_lkup_addr[3:0]);
      ss = int'(su_lkup_addr[3:0]);
      fs = int'(cd_wr_addr[3:0]);
      e_cd_vld  = cd_lkup_vld;
      e_su_vld  = su_lkup_vld;
      e_cd_way  = find_hit(cs, cd_lkup_addr[31:4]);
      e_su_way  = find_hit(ss, su_lkup_addr[31:4]);
      e_cd_st   = (e_cd_way >= 0) ? m_st[cs][e_cd_way]   : 2'd0;
      e_cd_data = (e_cd_way >= 0) ? m_data[cs][e_cd_way] : 32'd0;
      e_su_st   = (e_su_way >= 0) ? m_st[ss][e_su_way]   : 2'd0;
      e_su_data = (e_su_way >= 0) ? m_data[ss][e_su_way] : 32'd0;
      e_vic_way  = pick_victim(cs);
      e_vic_st   = m_st[cs][e_vic_way];
      e_vic_tag  = m_tag[cs][e_vic_way];
      e_vic_data = m_data[cs][e_vic_way];
      if (cd_lkup_vld && e_cd_way >= 0 && !(cd_wr_en && cd_wr_tag_en && fs == cs))
        touch(cs, e_cd_way);
      if (cd_wr_en && cd_wr_tag_en) touch(fs, int'(cd_wr_way));
      if (su_wr_en && su_wr_st_en)  m_st[su_wr_addr[3:0]][su_wr_way]   = su_wr_st;
      if (su_wr_en && su_wr_dat_en) m_data[su_wr_addr[3:0]][su_wr_way] = su_wr_data;
      if (cd_wr_en && cd_wr_st_en)  m_st[fs][cd_wr_way]   = cd_wr_st;
      if (cd_wr_en && cd_wr_tag_en) m_tag[fs][cd_wr_way]  = cd_wr_addr[31:4];
      if (cd_wr_en && cd_wr_dat_en) m_data[fs][cd_wr_way] = cd_wr_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("init_done", init_done, m_ready);
      check("cd_rsp_vld", cd_rsp_vld, e_cd_vld);
      check("su_rsp_vld", su_rsp_vld, e_su_vld);
      if (e_cd_vld) begin
        check("cd_hit", cd_hit, e_cd_way >= 0);
        check("cd_hit_way", cd_hit_way, (e_cd_way >= 0) ? e_cd_way : 0);
        check("cd_st", cd_st, e_cd_st);
        check("cd_data", cd_data, e_cd_data);
        check("cd_victim_way", cd_victim_way, e_vic_way);
        check("cd_victim_st", cd_victim_st, e_vic_st);
        check("cd_victim_tag", cd_victim_tag, e_vic_tag);
        check("cd_victim_data", cd_victim_data, e_vic_data);
      end
      if (e_su_vld) begin
        check("su_hit", su_hit, e_su_way >= 0);
        check("su_hit_way", su_hit_way, (e_su_way >= 0) ? e_su_way : 0);
        check("su_st", su_st, e_su_st);
        check("su_data", su_data, e_su_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cd_lkup_vld = 0; cd_lkup_addr = '0; su_lkup_vld = 0; su_lkup_addr = '0;
    cd_wr_en = 0; cd_wr_addr = '0; cd_wr_way = '0; cd_wr_st_en = 0;
    cd_wr_tag_en = 0; cd_wr_dat_en = 0; cd_wr_st = '0; cd_wr_data = '0;
    su_wr_en = 0; su_wr_addr = '0; su_wr_way = '0; su_wr_st_en = 0;
    su_wr_dat_en = 0; su_wr_st = '0; su_wr_data = '0;
  endtask

  task automatic cd_lookup(input logic [31:0] a);
    cd_lkup_vld = 1'b1; cd_lkup_addr = a;
    tick();
    cd_lkup_vld = 1'b0;
  endtask

  task automatic cd_fill(input logic [1:0] way, input logic [27:0] tag, input logic [31:0] d);
    cd_wr_en = 1; cd_wr_addr = {tag, 4'h5}; cd_wr_way = way;
    cd_wr_st_en = 1; cd_wr_tag_en = 1; cd_wr_dat_en = 1; cd_wr_st = 2'd2; cd_wr_data = d;
    tick();
    idle();
  endtask

  task automatic wait_sweep(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) check({tag, "_init_low_c16"}, init_done, 1'b0);
      if (k == 16) check({tag, "_init_high_c17"}, init_done, 1'b1);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_cd_rsp_vld", cd_rsp_vld, 1'b0);
    check("rst_cd_victim_way", cd_victim_way, 2'd0);
    rst = 1'b0;
    check("rst_init_done", init_done, 1'b0);
    wait_sweep("boot");

    cd_lookup(32'h0000_0005);
    check("empty_rsp_vld", cd_rsp_vld, 1'b1);
    check("empty_hit", cd_hit, 1'b0);
    check("empty_st", cd_st, 2'd0);
    check("empty_victim", cd_victim_way, 2'd0);
    tick();
    check("rsp_one_cycle", cd_rsp_vld, 1'b0);

    for (int w = 0; w < 4; w++) cd_fill(2'(w), 28'(w + 1), 32'hA0 + 32'(w));
    cd_lookup(32'h0000_0035);
    check("fill_hit", cd_hit, 1'b1);
    check("fill_hit_way", cd_hit_way, 2'd2);
    check("fill_data", cd_data, 32'hA2);
    check("fill_st", cd_st, 2'd2);

    for (int w = 0; w < 4; w++) cd_lookup({28'(w + 1), 4'h5});
    cd_lookup(32'h0000_0015);
    check("plru_after_0123", cd_victim_way, 2'd0);
    cd_lookup(32'h0000_0095);
    check("plru_after_hit0", cd_victim_way, 2'd2);
    check("plru_miss", cd_hit, 1'b0);

    cd_wr_en = 1; cd_wr_addr = 32'h25; cd_wr_way = 2'd1; cd_wr_st_en = 1; cd_wr_st = 2'd3;
    su_wr_en = 1; su_wr_addr = 32'h25; su_wr_way = 2'd1; su_wr_st_en = 1; su_wr_st = 2'd1;
    tick();
    idle();
    cd_lookup(32'h0000_0025);
    check("conflict_cd_wins", cd_st, 2'd3);
    cd_wr_en = 1; cd_wr_addr = 32'h35; cd_wr_way = 2'd2; cd_wr_st_en = 1; cd_wr_st = 2'd1;
    su_wr_en = 1; su_wr_addr = 32'h45; su_wr_way = 2'd3; su_wr_st_en = 1; su_wr_st = 2'd3;
    tick();
    idle();
    cd_lookup(32'h0000_0035);
    check("diff_way_cd", cd_st, 2'd1);
    su_lkup_vld = 1; su_lkup_addr = 32'h45;
    tick();
    su_lkup_vld = 0;
    check("diff_way_su", su_st, 2'd3);

    cd_wr_en = 1; cd_wr_addr = 32'h15; cd_wr_way = 2'd0; cd_wr_dat_en = 1; cd_wr_data = 32'h55;
    cd_lookup(32'h0000_0015);
    idle();
    check("rdw_old_data", cd_data, 32'hA0);
    cd_lookup(32'h0000_0015);
    check("rdw_new_data", cd_data, 32'h55);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_sweep("restart");
    cd_lookup(32'h0000_0015);
    check("restart_hit", cd_hit, 1'b0);
    check("restart_st", cd_st, 2'd0);

    for (int n = 0; n < 3000; n++) begin
      cd_lkup_vld  = $urandom_range(0, 2) != 0;
      cd_lkup_addr = {28'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      su_lkup_vld  = $urandom_range(0, 1) != 0;
      su_lkup_addr = {28'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      cd_wr_en     = $urandom_range(0, 2) == 0;
      cd_wr_addr   = {28'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      cd_wr_way    = 2'($urandom_range(0, 3));
      cd_wr_st_en  = $urandom_range(0, 1) != 0;
      cd_wr_tag_en = $urandom_range(0, 1) != 0;
      cd_wr_dat_en = $urandom_range(0, 1) != 0;
      cd_wr_st     = 2'($urandom_range(0, 3));
      cd_wr_data   = $urandom;
      su_wr_en     = $urandom_range(0, 2) == 0;
      su_wr_addr   = {28'($urandom), 4'($urandom_range(0, 3))};
      su_wr_way    = 2'($urandom_range(0, 3));
      su_wr_st_en  = $urandom_range(0, 1) != 0;
      su_wr_dat_en = $urandom_range(0, 1) != 0;
      su_wr_st     = 2'($urandom_range(0, 3));
      su_wr_data   = $urandom;
      rst          = $urandom_range(0, 599) == 0;
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
